// File: rtl/tt_host_bridge_pkg.sv
// Shared opcodes, status bytes, FSM states and small helpers for tt_host_bridge.
package tt_host_bridge_pkg;

    localparam logic [7:0] OP_WR  = 8'h01;
    localparam logic [7:0] OP_RD  = 8'h02;
    localparam logic [7:0] OP_WRN = 8'h03;
    localparam logic [7:0] OP_RDN = 8'h04;

    localparam logic [7:0] ST_OK    = 8'hA5;
    localparam logic [7:0] ST_BADOP = 8'hE1;
    localparam logic [7:0] ST_TMO   = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_byte_shifter.sv
// MSB-first byte shift register: parallel load, shift a byte in at the bottom,
// or shift the top byte out, with a count of shifts since the last load.
module tt_byte_shifter #(
    parameter int unsigned N_BYTES = 4,
    parameter int unsigned CNT_W   = $clog2(N_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [N_BYTES*8-1:0]   load_val_i,
    input  logic                   shift_in_i,
    input  logic [7:0]             byte_i,
    input  logic                   shift_out_i,
    output logic [7:0]             top_byte_o,
    output logic [N_BYTES*8-1:0]   nxt_o_c,
    output logic [CNT_W-1:0]       cnt_o
);

    localparam int unsigned W = N_BYTES * 8;

    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Value after shifting byte_i in; lets the owner capture a full word on the last byte.
    assign nxt_o_c = W'(data_q << 8) | W'(byte_i);

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_val_i;
            cnt_d  = '0;
        end else if (shift_in_i) begin
            data_d = nxt_o_c;
            cnt_d  = cnt_q + CNT_W'(1);
        end else if (shift_out_i) begin
            data_d = W'(data_q << 8);
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign top_byte_o = data_q[W-1 -: 8];
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/tt_host_bridge.sv
// Byte-serial host command bridge to a single-word memory bus with timeout.
// Optional TT_HOST_BRIDGE_AUTOINC_EN: post-increment address and write-next/read-next opcodes.
module tt_host_bridge
    import tt_host_bridge_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned DATA_BYTES = DATA_W / 8;
    localparam int unsigned ADDR_BYTES = ADDR_W / 8;
    localparam int unsigned CMD_W      = max_u(ADDR_W, DATA_W);
    localparam int unsigned CMD_BYTES  = CMD_W / 8;
    localparam int unsigned CMD_CW     = $clog2(CMD_BYTES + 1);
    localparam int unsigned RESP_CW    = $clog2(DATA_BYTES + 1);
    localparam int unsigned TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [7:0]          out_byte_q, out_byte_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [RESP_CW-1:0]  resp_rem_q, resp_rem_d;

    logic                cmd_load, cmd_shift;
    logic [CMD_W-1:0]    cmd_nxt;
    logic [CMD_CW-1:0]   cmd_cnt;
    logic [7:0]          cmd_unused_top;

    logic                resp_load, resp_shift;
    logic [DATA_W-1:0]   resp_load_val;
    logic [7:0]          resp_top;
    logic [RESP_CW-1:0]  resp_cnt;
    logic [DATA_W-1:0]   resp_unused_nxt;

    // Assembles address and write-data bytes from the host.
    tt_byte_shifter #(
        .N_BYTES (CMD_BYTES),
        .CNT_W   (CMD_CW)
    ) u_cmd (
        .clk         (clk),
        .rst         (rst),
        .load_i      (cmd_load),
        .load_val_i  ('0),
        .shift_in_i  (cmd_shift),
        .byte_i      (in_byte),
        .shift_out_i (1'b0),
        .top_byte_o  (cmd_unused_top),
        .nxt_o_c     (cmd_nxt),
        .cnt_o       (cmd_cnt)
    );

    // Holds the read-data bytes still to be sent after the first response byte.
    tt_byte_shifter #(
        .N_BYTES (DATA_BYTES),
        .CNT_W   (RESP_CW)
    ) u_resp (
        .clk         (clk),
        .rst         (rst),
        .load_i      (resp_load),
        .load_val_i  (resp_load_val),
        .shift_in_i  (1'b0),
        .byte_i      (8'h00),
        .shift_out_i (resp_shift),
        .top_byte_o  (resp_top),
        .nxt_o_c     (resp_unused_nxt),
        .cnt_o       (resp_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            out_byte_q  <= 8'h00;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= '0;
            resp_rem_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            tmo_q       <= tmo_d;
            resp_rem_q  <= resp_rem_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        out_byte_d    = 8'h00;
        out_valid_d   = 1'b0;
        tmo_d         = tmo_q;
        resp_rem_d    = resp_rem_q;
        cmd_load      = 1'b0;
        cmd_shift     = 1'b0;
        resp_load     = 1'b0;
        resp_load_val = '0;
        resp_shift    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && ena) begin
                    cmd_load = 1'b1;
                    if (in_byte == OP_WR || in_byte == OP_RD) begin
                        bus_we_d = (in_byte == OP_WR);
                        state_d  = S_ADDR;
`ifdef TT_HOST_BRIDGE_AUTOINC_EN
                    end else if (in_byte == OP_WRN) begin
                        bus_we_d = 1'b1;
                        state_d  = S_DATA;
                    end else if (in_byte == OP_RDN) begin
                        bus_we_d  = 1'b0;
                        bus_req_d = 1'b1;
                        tmo_d     = '0;
                        state_d   = S_BUS;
`endif
                    end else begin
                        out_byte_d  = ST_BADOP;
                        out_valid_d = 1'b1;
                        resp_load   = 1'b1;
                        resp_rem_d  = '0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (in_valid) begin
                    cmd_shift = 1'b1;
                    if (cmd_cnt == CMD_CW'(ADDR_BYTES - 1)) begin
                        bus_addr_d = ADDR_W'(cmd_nxt);
                        cmd_load   = 1'b1;
                        if (bus_we_q) begin
                            state_d = S_DATA;
                        end else begin
                            bus_req_d = 1'b1;
                            tmo_d     = '0;
                            state_d   = S_BUS;
                        end
                    end
                end
            end
            S_DATA: begin
                if (in_valid) begin
                    cmd_shift = 1'b1;
                    if (cmd_cnt == CMD_CW'(DATA_BYTES - 1)) begin
                        bus_wdata_d = DATA_W'(cmd_nxt);
                        cmd_load    = 1'b1;
                        bus_req_d   = 1'b1;
                        tmo_d       = '0;
                        state_d     = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // An ack on the final timeout cycle wins over the timeout.
                if (bus_ack) begin
                    bus_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    resp_load   = 1'b1;
                    state_d     = S_RESP;
                    if (bus_we_q) begin
                        out_byte_d = ST_OK;
                        resp_rem_d = '0;
                    end else begin
                        out_byte_d    = bus_rdata[DATA_W-1 -: 8];
                        resp_load_val = DATA_W'(bus_rdata << 8);
                        resp_rem_d    = RESP_CW'(DATA_BYTES - 1);
                    end
`ifdef TT_HOST_BRIDGE_AUTOINC_EN
                    bus_addr_d = bus_addr_q + ADDR_W'(DATA_BYTES);
`endif
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    bus_req_d   = 1'b0;
                    out_byte_d  = ST_TMO;
                    out_valid_d = 1'b1;
                    resp_load   = 1'b1;
                    resp_rem_d  = '0;
                    state_d     = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RESP: begin
                if (resp_cnt == resp_rem_q) begin
                    state_d = S_IDLE;
                end else begin
                    out_byte_d  = resp_top;
                    out_valid_d = 1'b1;
                    resp_shift  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_tt_host_bridge.sv
// Self-checking bench for tt_host_bridge: transaction model plus per-cycle output compare.
module tb_tt_host_bridge;
    import tt_host_bridge_pkg::*;

    localparam int unsigned TMO = 8;
`ifdef TT_HOST_BRIDGE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        busy;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    tt_host_bridge #(
        .DATA_W  (32),
        .ADDR_W  (16),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .busy      (busy),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: address register, expected bus access, expected response bytes.
    logic [15:0] m_addr = 16'h0000;
    logic        exp_bus_active = 1'b0;
    logic [15:0] exp_addr = 16'h0000;
    logic        exp_we = 1'b0;
    logic [31:0] exp_wdata = 32'h0;
    logic [7:0]  exp_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0)
                chk("out_unexpected", {63'd0, out_valid}, 64'd0);
            else if (out_valid)
                chk("out_byte", {56'd0, out_byte}, {56'd0, exp_q.pop_front()});
            if (!exp_bus_active) begin
                chk("bus_req_unexpected", {63'd0, bus_req}, 64'd0);
            end else if (bus_req) begin
                chk("bus_addr", {48'd0, bus_addr}, {48'd0, exp_addr});
                chk("bus_we", {63'd0, bus_we}, {63'd0, exp_we});
                if (exp_we) chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, exp_wdata});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bus_req_seen", {63'd0, bus_req}, 64'd1);
    endtask

    // Send a bus command and return on the first cycle bus_req is high.
    task automatic start_access(input logic [7:0] op, input logic [15:0] a, input logic [31:0] d);
        logic full_addr;
        full_addr      = (op == OP_WR || op == OP_RD);
        exp_addr       = full_addr ? a : m_addr;
        exp_we         = (op == OP_WR || op == OP_WRN);
        exp_wdata      = d;
        m_addr         = exp_addr;
        exp_bus_active = 1'b1;
        send_byte(op);
        if (full_addr) begin
            send_byte(a[15:8]);
            send_byte(a[7:0]);
        end
        if (exp_we)
            for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        wait_req();
    endtask

    // Acknowledge after `delay` waiting cycles (or never); returns on the first response cycle.
    task automatic finish_access(input int delay, input bit give_ack, input logic [31:0] rd,
                                 output int rc);
        bit ok;
        ok = give_ack && (delay + 1 <= int'(TMO));
        if (!ok) exp_q.push_back(ST_TMO);
        else if (exp_we) exp_q.push_back(ST_OK);
        else for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
        rc = 0;
        while (bus_req && rc < 200) begin
            rc++;
            if (give_ack && rc == delay + 1) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
                @(negedge clk);
                bus_ack   = 1'b0;
                bus_rdata = 32'h0;
                break;
            end
            @(negedge clk);
        end
        exp_bus_active = 1'b0;
        if (ok && AUTOINC) m_addr = m_addr + 16'd4;
        chk("req_cycles", 64'(rc), ok ? 64'(delay + 1) : 64'(TMO));
        chk("resp_first_valid", {63'd0, out_valid}, 64'd1);
        chk("req_dropped", {63'd0, bus_req}, 64'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_resp_all"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_addr_after"}, {48'd0, bus_addr}, {48'd0, m_addr});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_byte"}, {56'd0, out_byte}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_bus_req"}, {63'd0, bus_req}, 64'd0);
        chk({tag, "_bus_we"}, {63'd0, bus_we}, 64'd0);
        chk({tag, "_bus_addr"}, {48'd0, bus_addr}, 64'd0);
        chk({tag, "_bus_wdata"}, {32'd0, bus_wdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        rst       = 1'b1;
        ena       = 1'b1;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;
        @(negedge clk);

        // Write 0xDEADBEEF to 0x0010, ack after 3 waiting cycles.
        start_access(OP_WR, 16'h0010, 32'hDEADBEEF);
        chk("wr_addr", {48'd0, bus_addr}, 64'h0010);
        chk("wr_data", {32'd0, bus_wdata}, 64'hDEADBEEF);
        chk("wr_we", {63'd0, bus_we}, 64'd1);
        finish_access(3, 1'b1, 32'h0, rc);
        chk("wr_resp", {56'd0, out_byte}, 64'hA5);
        drain("wr");

        // Read 0x0020 returning 0x12345678: four consecutive response bytes.
        start_access(OP_RD, 16'h0020, 32'h0);
        finish_access(1, 1'b1, 32'h12345678, rc);
        chk("rd_b0", {56'd0, out_byte}, 64'h12);
        @(negedge clk);
        chk("rd_b1", {55'd0, out_valid, out_byte}, 64'h134);
        @(negedge clk);
        chk("rd_b2", {55'd0, out_valid, out_byte}, 64'h156);
        @(negedge clk);
        chk("rd_b3", {55'd0, out_valid, out_byte}, 64'h178);
        @(negedge clk);
        chk("rd_busy_after", {62'd0, busy, out_valid}, 64'd0);
        drain("rd");

        // Unknown opcode gives a single 0xE1 and no bus request.
        exp_q.push_back(ST_BADOP);
        send_byte(8'h7F);
        chk("badop_resp", {55'd0, out_valid, out_byte}, 64'h1E1);
        drain("badop");

        // Host byte while not selected is ignored.
        ena = 1'b0;
        send_byte(OP_WR);
        repeat (3) @(negedge clk);
        chk("ena0_busy", {63'd0, busy}, 64'd0);
        ena = 1'b1;

        // No ack: bus_req for exactly TIMEOUT cycles, then 0xEE.
        start_access(OP_RD, 16'h0040, 32'h0);
        finish_access(0, 1'b0, 32'h0, rc);
        chk("tmo_cycles", 64'(rc), 64'd8);
        chk("tmo_resp", {56'd0, out_byte}, 64'hEE);
        drain("tmo");

        // Ack on the last allowed cycle is a success.
        start_access(OP_RD, 16'h0050, 32'h0);
        finish_access(7, 1'b1, 32'hCAFEF00D, rc);
        chk("edge_cycles", 64'(rc), 64'd8);
        chk("edge_resp", {56'd0, out_byte}, 64'hCA);
        drain("edge");

        // Reset in the middle of the address phase.
        send_byte(OP_WR);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_addr");
        m_addr = 16'h0000;
        rst = 1'b0;
        @(negedge clk);

        // Reset while bus_req is held.
        start_access(OP_RD, 16'h0030, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_bus");
        exp_bus_active = 1'b0;
        m_addr = 16'h0000;
        rst = 1'b0;
        @(negedge clk);

        // A full write completes normally after the resets.
        start_access(OP_WR, 16'h1234, 32'h01020304);
        finish_access(0, 1'b1, 32'h0, rc);
        chk("post_rst_resp", {56'd0, out_byte}, 64'hA5);
        drain("post_rst");

`ifdef TT_HOST_BRIDGE_AUTOINC_EN
        // Write at 0xFFFC, then write-next wraps to 0x0000, then read-next at 0x0004.
        start_access(OP_WR, 16'hFFFC, 32'h11223344);
        finish_access(0, 1'b1, 32'h0, rc);
        drain("ai_wr");
        chk("ai_wrap_model", {48'd0, m_addr}, 64'h0000);
        start_access(OP_WRN, 16'h0000, 32'h55667788);
        chk("ai_wrap_addr", {48'd0, bus_addr}, 64'h0000);
        finish_access(2, 1'b1, 32'h0, rc);
        drain("ai_wrn");
        start_access(OP_RDN, 16'h0000, 32'h0);
        chk("ai_rdn_addr", {48'd0, bus_addr}, 64'h0004);
        finish_access(0, 1'b1, 32'hA1B2C3D4, rc);
        drain("ai_rdn");
`else
        // Without auto-increment the next-opcodes are unknown.
        exp_q.push_back(ST_BADOP);
        send_byte(OP_WRN);
        chk("wrn_badop", {55'd0, out_valid, out_byte}, 64'h1E1);
        drain("wrn");
        exp_q.push_back(ST_BADOP);
        send_byte(OP_RDN);
        chk("rdn_badop", {55'd0, out_valid, out_byte}, 64'h1E1);
        drain("rdn");
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
